// File: rtl/timer_pkg.sv
// Shared encodings and BCD helpers for the countdown timer and its button front end.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [7:0] SEC_MAX  = {BCD_FIVE, BCD_NINE};
    localparam logic [7:0] MIN_MAX  = {BCD_NINE, BCD_NINE};

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;
    localparam int NUM_BTN   = 5;

    // Two-digit BCD increment/decrement that wraps between 00 and max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == BCD_NINE)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, BCD_NINE};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer; pulses press for one cycle on an accepted rise.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer: button editing of a BCD preset, 1 s countdown, self-clearing alarm.
//   state    | meaning
//   ST_IDLE  | editing preset, display shows preset
//   ST_RUN   | counting down on each tick
//   ST_PAUSE | count and tick phase frozen
//   ST_ALARM | alarm raised, clears on a press or after ALARM_SECS ticks
module countdown_timer
    import timer_pkg::*;
#(
    parameter int          CLK_HZ          = 100_000_000,
    parameter int          TICK_DIV        = CLK_HZ,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          ALARM_SECS      = 10,
    parameter logic [15:0] PRESET_INIT     = 16'h0010
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    output logic [15:0] bcd_digits,
    output logic [1:0]  state,
    output logic        edit_field,
    output logic        alarm
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    assign raw[BTN_UP]    = btn_up;
    assign raw[BTN_DOWN]  = btn_down;
    assign raw[BTN_LEFT]  = btn_left;
    assign raw[BTN_RIGHT] = btn_right;
    assign raw[BTN_ENTER] = btn_enter;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
            .clk   (clk_100mhz),
            .reset (reset),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    state_t        state_q, state_d;
    logic [15:0]   preset_q, preset_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   count_dec;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          edit_q, edit_d;
    logic          alarm_q, alarm_d;
    logic          tick;
    logic          act_enter, act_left, act_right, act_up, act_down, any_press;

    // Only the highest-priority press of a cycle is acted on.
    always_comb begin
        act_enter = press[BTN_ENTER];
        act_left  = press[BTN_LEFT] && !press[BTN_ENTER];
        act_right = press[BTN_RIGHT] && !press[BTN_LEFT] && !press[BTN_ENTER];
        act_up    = press[BTN_UP] && !(press[BTN_ENTER] || press[BTN_LEFT] || press[BTN_RIGHT]);
        act_down  = press[BTN_DOWN] && !(press[BTN_ENTER] || press[BTN_LEFT] ||
                                         press[BTN_RIGHT] || press[BTN_UP]);
        any_press = |press;
    end

    assign tick = ((state_q == ST_RUN) || (state_q == ST_ALARM)) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        if (count_q[7:0] != 8'h00)
            count_dec = {count_q[15:8], bcd_dec(count_q[7:0], SEC_MAX)};
        else
            count_dec = {bcd_dec(count_q[15:8], MIN_MAX), SEC_MAX};
    end

    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        count_d     = count_q;
        tick_cnt_d  = tick_cnt_q;
        alarm_cnt_d = alarm_cnt_q;
        edit_d      = edit_q;
        case (state_q)
            ST_IDLE: begin
                if (act_enter) begin
                    if (preset_q != 16'h0000) begin
                        state_d    = ST_RUN;
                        count_d    = preset_q;
                        tick_cnt_d = '0;
                    end
                end else if (act_left || act_right) begin
                    edit_d = !edit_q;
                end else if (act_up) begin
                    if (edit_q) preset_d[15:8] = bcd_inc(preset_q[15:8], MIN_MAX);
                    else        preset_d[7:0]  = bcd_inc(preset_q[7:0], SEC_MAX);
                end else if (act_down) begin
                    if (edit_q) preset_d[15:8] = bcd_dec(preset_q[15:8], MIN_MAX);
                    else        preset_d[7:0]  = bcd_dec(preset_q[7:0], SEC_MAX);
                end
            end
            ST_RUN: begin
                // A tick coinciding with enter still decrements; reaching zero beats the pause.
                if (tick) begin
                    tick_cnt_d = '0;
                    count_d    = count_dec;
                    if (count_dec == 16'h0000) begin
                        state_d     = ST_ALARM;
                        alarm_cnt_d = '0;
                    end else if (act_enter) begin
                        state_d = ST_PAUSE;
                    end
                end else if (act_enter) begin
                    state_d = ST_PAUSE;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            ST_PAUSE: begin
                if (act_enter)     state_d = ST_RUN;
                else if (act_left) state_d = ST_IDLE;
            end
            ST_ALARM: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick)
                    alarm_cnt_d = alarm_cnt_q + AW'(1);
                if (any_press || (tick && (alarm_cnt_q == ALARM_LAST)))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        alarm_d = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            preset_q    <= PRESET_INIT;
            count_q     <= PRESET_INIT;
            tick_cnt_q  <= '0;
            alarm_cnt_q <= '0;
            edit_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            tick_cnt_q  <= tick_cnt_d;
            alarm_cnt_q <= alarm_cnt_d;
            edit_q      <= edit_d;
            alarm_q     <= alarm_d;
        end
    end

    assign state      = state_q;
    assign bcd_digits = (state_q == ST_IDLE) ? preset_q : count_q;
    assign edit_field = edit_q;
    assign alarm      = alarm_q;

endmodule
